ctr_drbg_update_gen: RTL and testbench
======================================

// Module: ctr_drbg_update_gen
// PURPOSE
// - Producer side of the CTR_DRBG update path. Builds the 384-bit provided_data word consumed by the update block.
// - Encrypts V+1, V+2 and V+3 under Key using an external AES-256 core through a req/ack handshake.
// - Concatenates the three ciphertexts, XORs the result with additional data and presents it with a one-cycle done.
// - Sits between the DRBG state registers (key/v) and the update block in the non-derivation-function CTR_DRBG.
// PARAMETERS
// - KEY_W  256  key width; SEED_W = KEY_W + BLK_W (localparam, 384)
// - BLK_W  128  AES block width and V width; NBLK = SEED_W/BLK_W (localparam, 3)
// - CTR_W  32   width of the counter field of V; only V[CTR_W-1:0] is incremented
// PORTS
// - clk            in   1       rising-edge clock
// - rst_n          in   1       asynchronous reset, active-low
// - start          in   1       pulse; begins one update-generation pass
// - key_in         in   256     current DRBG key
// - v_in           in   128     current DRBG V
// - add_data       in   384     additional input, XORed into the result
// - busy           out  1       high from the cycle after start is accepted until done
// - aes_req        out  1       request to AES core; level, held until aes_ack
// - aes_key        out  256     key presented to AES; stable while busy
// - aes_block      out  128     plaintext presented to AES; stable while aes_req high
// - aes_ack        in   1       AES result valid; consumes the currently presented block
// - aes_result     in   128     ciphertext, sampled on the cycle aes_ack is high
// - provided_data  out  384     {new_key, new_v}; valid with done, held until next done
// - done           out  1       one-cycle pulse, provided_data valid
// BEHAVIOUR
// - Reset values: busy=0, aes_req=0, aes_key=0, aes_block=0, provided_data=0, done=0; FSM=IDLE, blk_cnt=0.
// - The reset is asynchronous. Reset in mid-pass aborts the pass immediately: aes_req drops, no done, and provided_data clears to 0.
// - FSM states: IDLE -> REQ -> (REQ, repeated once per block) -> FIN -> IDLE.
// - IDLE, on start=1: latch key_in, v_in and add_data. Compute vw = v_in with low CTR_W bits + 1. Go to REQ; busy=1.
// - REQ: aes_req=1, aes_block=vw, aes_key=latched key.
//   - On aes_ack=1, store aes_result into temp[SEED_W-1-blk_cnt*BLK_W -: BLK_W]. Block 0 is the most significant.
//   - After storing: increment blk_cnt and vw.
//   - If blk_cnt was NBLK-1, go to FIN and drop aes_req next cycle. Otherwise stay in REQ and present the new block next cycle.
// - An ack in the same cycle req rises is valid. A zero-wait responder (ack tied to req) completes one block per cycle.
// - FIN: provided_data <= temp ^ add_data; done=1 for exactly one cycle; busy=0; return to IDLE.
// - Latency: with ack on every req cycle, done is high exactly 4 cycles after the cycle start is sampled.
// - Counter arithmetic: vw[CTR_W-1:0] increments modulo 2^CTR_W. vw[BLK_W-1:CTR_W] never changes. A carry out of the field is discarded.
// - start while busy is ignored; the latched inputs do not change.
// - start in the same cycle as done is accepted; the next pass begins.
// - aes_ack outside REQ is ignored.
// - aes_result is sampled only on an ack cycle.
// - provided_data is registered. It never changes except on the done cycle or on reset.
// CONFIGURATION
// - CTR_UPD_ADD_DATA_EN defined: provided_data = temp ^ add_data, latched at start.
// - CTR_UPD_ADD_DATA_EN undefined: add_data is ignored and not latched (no 384-bit register); provided_data = temp.
// - Handshake, latency and all other behaviour are identical in both builds.
// TESTING
// - The bench AES model returns aes_result = aes_block (identity), with ack in the cycle req is seen, unless a test states otherwise.
// - Basic: key=0, v=0, add=0, start -> done at +4 cycles; provided_data = {128'h1, 128'h2, 128'h3}.
// - XOR (macro on): v=0, add={384{1'b1}} -> provided_data = ~{128'h1, 128'h2, 128'h3}.
//   - Macro off: same stimulus -> {128'h1, 128'h2, 128'h3}.
// - Wrap: CTR_W=32, v=128'hAAAA..._FFFFFFFE -> blocks have low words FFFFFFFF, 00000000, 00000001; upper 96 bits stay AAAA...
// - Stall/ignore: ack delayed 5 cycles per block, start re-pulsed while busy, and a stray ack in IDLE:
//   - aes_block is stable while req is high.
//   - Exactly 3 acks are consumed and one done occurs.
//   - done is high 1 + 3*6 cycles after start.
// - Reset mid-op: rst_n low during block 1 -> aes_req=0, busy=0, provided_data=0 immediately, and no done.
//   - A subsequent start completes normally.
// - Back-to-back: start asserted on the done cycle with a new v=5 -> second done gives {128'h6, 128'h7, 128'h8}.

Source files
------------

// File: rtl/ctr_drbg_update_gen.sv
// CTR_DRBG update-data producer: encrypts V+1..V+NBLK under Key via an external AES core.
// Define CTR_UPD_ADD_DATA_EN to XOR additional input into the result.
module ctr_drbg_update_gen #(
    parameter int KEY_W = 256,
    parameter int BLK_W = 128,
    parameter int CTR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [KEY_W-1:0]         key_in,
    input  logic [BLK_W-1:0]         v_in,
    input  logic [KEY_W+BLK_W-1:0]   add_data,
    output logic                     busy,
    output logic                     aes_req,
    output logic [KEY_W-1:0]         aes_key,
    output logic [BLK_W-1:0]         aes_block,
    input  logic                     aes_ack,
    input  logic [BLK_W-1:0]         aes_result,
    output logic [KEY_W+BLK_W-1:0]   provided_data,
    output logic                     done
);

    localparam int SEED_W = KEY_W + BLK_W;
    localparam int NBLK   = SEED_W / BLK_W;
    localparam int CNT_W  = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBLK - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FIN
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    blk_cnt_q;
    logic [KEY_W-1:0]    key_q;
    logic [BLK_W-1:0]    vw_q;
    logic [SEED_W-1:0]   temp_q, temp_d;
    logic [SEED_W-1:0]   prov_q;
    logic                load;
    logic                take;
    logic                last;

    // Only the low counter field advances; carries out of it are dropped.
    function automatic logic [BLK_W-1:0] inc_ctr(input logic [BLK_W-1:0] v);
        inc_ctr = {v[BLK_W-1:CTR_W], v[CTR_W-1:0] + {{(CTR_W-1){1'b0}}, 1'b1}};
    endfunction

`ifdef CTR_UPD_ADD_DATA_EN
    logic [SEED_W-1:0]   add_q;
`else
    logic                unused_add;
    assign unused_add = ^add_data;
`endif

    assign load = start && (state_q == IDLE || state_q == FIN);
    assign last = (blk_cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        temp_d  = temp_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = REQ;
            end
            REQ: begin
                if (aes_ack) begin
                    take = 1'b1;
                    for (int i = 0; i < NBLK; i++) begin
                        if (blk_cnt_q == CNT_W'(i))
                            temp_d[SEED_W-1-i*BLK_W -: BLK_W] = aes_result;
                    end
                    if (last) state_d = FIN;
                end
            end
            FIN: begin
                state_d = start ? REQ : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            blk_cnt_q <= '0;
            key_q     <= '0;
            vw_q      <= '0;
            temp_q    <= '0;
            prov_q    <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                key_q     <= key_in;
                vw_q      <= inc_ctr(v_in);
                blk_cnt_q <= '0;
            end else if (take) begin
                temp_q    <= temp_d;
                vw_q      <= inc_ctr(vw_q);
                blk_cnt_q <= last ? '0 : blk_cnt_q + 1'b1;
                // Result lands together with the move to FIN so it is valid with done.
                if (last) begin
`ifdef CTR_UPD_ADD_DATA_EN
                    prov_q <= temp_d ^ add_q;
`else
                    prov_q <= temp_d;
`endif
                end
            end
        end
    end

`ifdef CTR_UPD_ADD_DATA_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_q <= '0;
        end else if (load) begin
            add_q <= add_data;
        end
    end
`endif

    assign busy          = (state_q == REQ);
    assign aes_req       = (state_q == REQ);
    assign done          = (state_q == FIN);
    assign aes_key       = key_q;
    assign aes_block     = vw_q;
    assign provided_data = prov_q;

endmodule

// File: tb/tb_ctr_drbg_update_gen.sv
// Bench for ctr_drbg_update_gen with an identity AES responder and a result scoreboard.
module tb_ctr_drbg_update_gen;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [255:0] key_in;
    logic [127:0] v_in;
    logic [383:0] add_data;
    logic         busy;
    logic         aes_req;
    logic [255:0] aes_key;
    logic [127:0] aes_block;
    logic         aes_ack;
    logic [127:0] aes_result;
    logic [383:0] provided_data;
    logic         done;

    ctr_drbg_update_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .key_in        (key_in),
        .v_in          (v_in),
        .add_data      (add_data),
        .busy          (busy),
        .aes_req       (aes_req),
        .aes_key       (aes_key),
        .aes_block     (aes_block),
        .aes_ack       (aes_ack),
        .aes_result    (aes_result),
        .provided_data (provided_data),
        .done          (done)
    );

    always #5 clk = ~clk;

    // AES responder: identity cipher, ack after `delay` waiting cycles.
    int   delay = 0;
    int   wait_cnt = 0;
    logic stray = 1'b0;

    always @(posedge clk) begin
        if (aes_req && !aes_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    assign aes_ack    = (aes_req && wait_cnt == delay) || stray;
    assign aes_result = aes_block;

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int ack_cnt = 0;
    int stab_err = 0;
    logic [383:0] exp_q[$];

    logic         prev_req = 1'b0;
    logic         prev_ack = 1'b0;
    logic [127:0] prev_blk = '0;

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (aes_req && aes_ack) ack_cnt++;
        if (aes_req && prev_req && !prev_ack && aes_block !== prev_blk) stab_err++;
        prev_req = aes_req;
        prev_ack = aes_req && aes_ack;
        prev_blk = aes_block;
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done with empty scoreboard");
            end else begin
                chk("provided_data", provided_data, exp_q.pop_front());
            end
        end
    end

    function automatic logic [383:0] model(input logic [127:0] v, input logic [383:0] a);
        logic [383:0] t;
        logic [127:0] w;
        w = v;
        for (int i = 0; i < 3; i++) begin
            w[31:0] = w[31:0] + 32'd1;
            t[383-128*i -: 128] = w;
        end
`ifdef CTR_UPD_ADD_DATA_EN
        return t ^ a;
`else
        return t;
`endif
    endfunction

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_pass(input logic [255:0] k, input logic [127:0] v,
                            input logic [383:0] a, input logic [383:0] exp);
        int lat;
        @(negedge clk);
        key_in = k;
        v_in = v;
        add_data = a;
        start = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        chk("aes_key_latched", 384'(aes_key), 384'(k));
        chk("aes_req_high", 384'(aes_req), 384'd1);
        wait_done(lat);
        chk("latency", 384'(lat), 384'd4);
        chk("busy_at_done", 384'(busy), 384'd0);
    endtask

    typedef struct {
        logic [255:0] key;
        logic [127:0] v;
        logic [383:0] add;
        logic [383:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [383:0] base;
        logic [383:0] ra;
        logic [127:0] rv;
        logic [127:0] vw;
        int lat;
        int a0;
        int d0;

        base = {128'h1, 128'h2, 128'h3};
        vecs[0] = '{key: '0, v: '0, add: '0, exp: base};
`ifdef CTR_UPD_ADD_DATA_EN
        vecs[1] = '{key: {8{32'hC0FFEE01}}, v: '0, add: {384{1'b1}}, exp: ~base};
`else
        vecs[1] = '{key: {8{32'hC0FFEE01}}, v: '0, add: {384{1'b1}}, exp: base};
`endif
        vw = {96'hAAAAAAAA_AAAAAAAA_AAAAAAAA, 32'hFFFFFFFE};
        vecs[2] = '{key: {8{32'h12345678}}, v: vw, add: '0,
                    exp: {96'hAAAAAAAA_AAAAAAAA_AAAAAAAA, 32'hFFFFFFFF,
                          96'hAAAAAAAA_AAAAAAAA_AAAAAAAA, 32'h00000000,
                          96'hAAAAAAAA_AAAAAAAA_AAAAAAAA, 32'h00000001}};
        for (int n = 3; n < 5; n++) begin
            rv = {$urandom, $urandom, $urandom, $urandom};
            for (int j = 0; j < 12; j++) ra[32*j +: 32] = $urandom;
            vecs[n] = '{key: {8{$urandom}}, v: rv, add: ra, exp: model(rv, ra)};
        end

        rst_n = 1'b0;
        start = 1'b0;
        key_in = '0;
        v_in = '0;
        add_data = '0;
        #1;
        chk("rst_busy", 384'(busy), 384'd0);
        chk("rst_aes_req", 384'(aes_req), 384'd0);
        chk("rst_aes_key", 384'(aes_key), 384'd0);
        chk("rst_aes_block", 384'(aes_block), 384'd0);
        chk("rst_provided_data", provided_data, 384'd0);
        chk("rst_done", 384'(done), 384'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 5; n++) run_pass(vecs[n].key, vecs[n].v, vecs[n].add, vecs[n].exp);

        // Stall, stray ack in IDLE, start re-pulsed while busy
        delay = 5;
        @(negedge clk);
        d0 = done_cnt;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        chk("stray_ack_busy", 384'(busy), 384'd0);
        a0 = ack_cnt;
        key_in = {8{32'h0BADF00D}};
        v_in = 128'h10;
        add_data = '0;
        start = 1'b1;
        exp_q.push_back({128'h11, 128'h12, 128'h13});
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
            if (!done) begin
                start = (lat == 3);
                if (lat == 3) v_in = 128'h999;
            end
        end
        start = 1'b0;
        chk("stall_latency", 384'(lat), 384'd19);
        repeat (2) @(negedge clk);
        chk("stall_acks", 384'(ack_cnt - a0), 384'd3);
        chk("stall_dones", 384'(done_cnt - d0), 384'd1);
        chk("block_stable", 384'(stab_err), 384'd0);
        delay = 0;

        // Reset in the middle of block 1
        @(negedge clk);
        key_in = '0;
        v_in = '0;
        start = 1'b1;
        exp_q.push_back(base);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_block1", 384'(aes_block), 384'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 384'(aes_req), 384'd0);
        chk("mid_rst_busy", 384'(busy), 384'd0);
        chk("mid_rst_data", provided_data, 384'd0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_rst_no_done", 384'(done_cnt), 384'(d0));
        run_pass('0, 128'h40, '0, {128'h41, 128'h42, 128'h43});

        // Back-to-back: start on the done cycle
        @(negedge clk);
        v_in = 128'h20;
        start = 1'b1;
        exp_q.push_back({128'h21, 128'h22, 128'h23});
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("b2b_first_latency", 384'(lat), 384'd4);
        v_in = 128'h5;
        start = 1'b1;
        exp_q.push_back({128'h6, 128'h7, 128'h8});
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("b2b_second_latency", 384'(lat), 384'd4);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 384'(exp_q.size()), 384'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
